clock_sleep_ms: RTL and testbench
=================================

Name: clock_sleep_ms

Overview:
- Millisecond delay engine: the consumer side of the millisecond timebase.
- The caller loads a millisecond count and pulses start. The block counts clocks with a prescaler, then pulses done when the interval has elapsed.
- Uses the same start_port/done_port/return_port call convention as the clock_time block.
- Used by the XVC server logic for timeouts and JTAG settle delays.

Parameters:
- CLOCK_RATIO, 200000, clock cycles per millisecond (200 MHz clk, 5 ns period); legal range >= 2.
- DELAY_WIDTH, 32, width of delay_ms and return_port.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start_port  input  1  request; sampled only in IDLE.
- delay_ms  input  DELAY_WIDTH  requested delay in ms; captured on the accepting edge.
- done_port  output  1  one-cycle completion pulse.
- busy  output  1  high while a delay is in progress (RUN).
- return_port  output  DELAY_WIDTH  elapsed whole milliseconds of the current or last delay.

Behaviour:
- One clock; reset is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values: state=IDLE, done_port=0, busy=0, return_port=0, prescaler=0, latched target=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start_port=1, latch target=delay_ms, and clear prescaler and return_port to 0.
  - If delay_ms=0, go to DONE; otherwise go to RUN with busy=1.
- RUN, on each edge:
  - If prescaler=CLOCK_RATIO-1: prescaler<=0 and return_port<=return_port+1. Otherwise prescaler<=prescaler+1.
  - When the increment makes return_port equal to target: go to DONE, busy<=0.
- DONE:
  - done_port=1 for exactly one cycle; next edge returns to IDLE.
  - done_port is a registered output, asserted only while in DONE.
- Latency:
  - Let t0 be the accepting edge and N=delay_ms.
  - done_port is high during the single cycle following edge t0+N*CLOCK_RATIO.
  - For N=0 this is the cycle right after t0.
  - The next start can be accepted on edge t0+N*CLOCK_RATIO+2 at the earliest.
- start_port handling:
  - Ignored in RUN and DONE; no queuing, no restart. The caller must re-assert start_port in IDLE.
  - A level-held start_port re-triggers every time the block reaches IDLE.
- delay_ms changes after acceptance have no effect.
- return_port:
  - Counts live during RUN.
  - Holds the final value (=target) through DONE and IDLE until the next acceptance clears it.
- Width rules:
  - Prescaler width is $clog2(CLOCK_RATIO); it wraps exactly at CLOCK_RATIO-1 and never reaches CLOCK_RATIO.
  - return_port is unsigned DELAY_WIDTH and cannot overflow, since it stops at target <= 2^DELAY_WIDTH-1.
  - delay_ms=all-ones is legal.
- Reset:
  - Reset asserted mid-RUN or in DONE forces IDLE and reset values on that edge; no done_port pulse is produced.
  - Reset has priority over start_port on the same edge.
- No combinational path from any input to any output.

Test Plan:
- All runs use CLOCK_RATIO=4 overridden for simulation speed.
- Basic delay: start_port=1 one cycle with delay_ms=3, accepted at edge t0 -> busy high from t0 until edge t0+12; return_port steps 1,2,3 at edges t0+4, t0+8, t0+12; done_port high only in the cycle after edge t0+12.
- Zero delay: delay_ms=0 -> done_port high in the cycle after the accepting edge; busy never asserted; return_port=0.
- Ignored start: pulse start_port with delay_ms=9 at t0+5 during a 3 ms delay -> done still after t0+12; return_port ends at 3, not 9; no second done_port pulse.
- Reset mid-run: reset at edge t0+6 of a 3 ms delay -> edge t0+6 forces IDLE with all outputs 0; no done_port pulse through t0+20; a new delay_ms=1 start then completes after 4 cycles.
- Level-held start: start_port held high with delay_ms=1 -> done_port pulses periodically; the next start is accepted 2 edges after the previous completion edge, so accepting edges are 6 cycles apart, and pulses are exactly 6 cycles apart.
- Wide value: delay_ms=32'hFFFF_FFFF at CLOCK_RATIO=2 -> after 1000 cycles return_port=500 and busy=1; reset cleanly returns to IDLE.

Source files
------------

// File: rtl/clock_sleep_ms.sv
// clock_sleep_ms: millisecond delay engine.
// The caller loads a millisecond count and pulses start_port. A prescaler
// counts CLOCK_RATIO clocks per millisecond, return_port counts elapsed
// milliseconds, and done_port pulses for one cycle once the delay has elapsed.
// All outputs are registered, so no input reaches an output combinationally.

module clock_sleep_ms #(
    parameter int CLOCK_RATIO = 200000,
    parameter int DELAY_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_port,
    input  logic [DELAY_WIDTH-1:0] delay_ms,
    output logic                   done_port,
    output logic                   busy,
    output logic [DELAY_WIDTH-1:0] return_port
);

    // The prescaler only has to hold 0..CLOCK_RATIO-1.
    localparam int PS_W = (CLOCK_RATIO > 2) ? $clog2(CLOCK_RATIO) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLOCK_RATIO - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [PS_W-1:0]        prescaler_r;
    logic [PS_W-1:0]        next_prescaler_s;
    logic [DELAY_WIDTH-1:0] target_r;
    logic [DELAY_WIDTH-1:0] next_target_s;
    logic [DELAY_WIDTH-1:0] return_r;
    logic [DELAY_WIDTH-1:0] next_return_s;
    logic [DELAY_WIDTH-1:0] return_inc_s;
    logic                   busy_r;
    logic                   next_busy_s;
    logic                   done_r;
    logic                   next_done_s;

    // return_port never passes target, so this increment cannot wrap while in RUN.
    assign return_inc_s = return_r + DELAY_WIDTH'(1);

    // State and datapath registers; reset wins over everything on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            prescaler_r <= '0;
            target_r    <= '0;
            return_r    <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            prescaler_r <= next_prescaler_s;
            target_r    <= next_target_s;
            return_r    <= next_return_s;
            busy_r      <= next_busy_s;
            done_r      <= next_done_s;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so that busy/done_port/return_port come straight from flops.
    always_comb begin
        next_state_s     = state_r;
        next_prescaler_s = prescaler_r;
        next_target_s    = target_r;
        next_return_s    = return_r;
        next_busy_s      = busy_r;
        next_done_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start_port) begin
                    next_target_s    = delay_ms;
                    next_prescaler_s = '0;
                    next_return_s    = '0;
                    if (delay_ms == '0) begin
                        // Zero delay completes immediately without ever going busy.
                        next_state_s = ST_DONE;
                        next_busy_s  = 1'b0;
                        next_done_s  = 1'b1;
                    end else begin
                        next_state_s = ST_RUN;
                        next_busy_s  = 1'b1;
                        next_done_s  = 1'b0;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                    next_busy_s  = 1'b0;
                end
            end

            ST_RUN: begin
                if (prescaler_r == PS_MAX) begin
                    next_prescaler_s = '0;
                    next_return_s    = return_inc_s;
                    if (return_inc_s == target_r) begin
                        next_state_s = ST_DONE;
                        next_busy_s  = 1'b0;
                        next_done_s  = 1'b1;
                    end else begin
                        next_state_s = ST_RUN;
                        next_busy_s  = 1'b1;
                    end
                end else begin
                    next_prescaler_s = prescaler_r + PS_W'(1);
                    next_busy_s      = 1'b1;
                end
            end

            ST_DONE: begin
                // Single-cycle pulse; return_port keeps the final count.
                next_state_s = ST_IDLE;
                next_busy_s  = 1'b0;
                next_done_s  = 1'b0;
            end

            default: begin
                next_state_s     = ST_IDLE;
                next_prescaler_s = '0;
                next_busy_s      = 1'b0;
                next_done_s      = 1'b0;
            end
        endcase
    end

    assign done_port   = done_r;
    assign busy        = busy_r;
    assign return_port = return_r;

endmodule

// File: tb/tb_clock_sleep_ms.sv
// Self-checking bench for clock_sleep_ms. Main instance runs at CLOCK_RATIO=4
// against a timestamp-based reference model; a second instance at
// CLOCK_RATIO=2 exercises the all-ones delay value.

module tb_clock_sleep_ms;

    localparam int R  = 4;
    localparam int R2 = 2;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          start_port;
    logic [DW-1:0] delay_ms;
    logic          done_port;
    logic          busy;
    logic [DW-1:0] return_port;

    logic          reset2;
    logic          start2;
    logic [DW-1:0] delay2;
    logic          done2;
    logic          busy2;
    logic [DW-1:0] ret2;

    int total;
    int bad;

    // Reference model: a job is described by its accepting edge and length.
    longint edge_n;
    bit     have_job;
    longint t0;
    longint job_n;
    longint done_edges[$];

    clock_sleep_ms #(.CLOCK_RATIO(R), .DELAY_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_port (start_port),
        .delay_ms   (delay_ms),
        .done_port  (done_port),
        .busy       (busy),
        .return_port(return_port)
    );

    clock_sleep_ms #(.CLOCK_RATIO(R2), .DELAY_WIDTH(DW)) dut_wide (
        .clk        (clk),
        .reset      (reset2),
        .start_port (start2),
        .delay_ms   (delay2),
        .done_port  (done2),
        .busy       (busy2),
        .return_port(ret2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Advance one clock edge, update the model from the inputs seen on that
    // edge, then compare the main instance against the model.
    task automatic tick();
        longint k;
        longint span;
        bit     e_busy;
        bit     e_done;
        longint e_ret;
        @(posedge clk);
        edge_n++;
        if (reset) begin
            have_job = 1'b0;
        end else if (start_port && (!have_job || edge_n >= t0 + job_n * R + 2)) begin
            have_job = 1'b1;
            t0       = edge_n;
            job_n    = longint'(delay_ms);
        end
        e_busy = 1'b0;
        e_done = 1'b0;
        e_ret  = 0;
        if (have_job) begin
            k    = edge_n - t0;
            span = job_n * R;
            if (k < span) begin
                e_busy = 1'b1;
                e_ret  = k / R;
            end else begin
                e_ret  = job_n;
                e_done = (k == span);
            end
        end
        #1;
        check_val("busy", longint'(busy), longint'(e_busy));
        check_val("done_port", longint'(done_port), longint'(e_done));
        check_val("return_port", longint'(return_port), e_ret);
        if (done_port) done_edges.push_back(edge_n);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start(input logic [DW-1:0] d);
        start_port = 1'b1;
        delay_ms   = d;
        tick();
        start_port = 1'b0;
        delay_ms   = $urandom;
    endtask

    initial begin
        int pulses_before;
        total      = 0;
        bad        = 0;
        edge_n     = 0;
        have_job   = 1'b0;
        t0         = 0;
        job_n      = 0;
        reset      = 1'b1;
        start_port = 1'b0;
        delay_ms   = '0;
        reset2     = 1'b1;
        start2     = 1'b0;
        delay2     = '0;

        // Reset state.
        run(3);
        reset  = 1'b0;
        reset2 = 1'b0;
        run(2);

        // Basic 3 ms delay.
        pulse_start(32'd3);
        run(16);

        // Zero delay.
        pulse_start(32'd0);
        run(4);

        // Start during RUN is ignored.
        pulse_start(32'd3);
        run(4);
        pulse_start(32'd9);
        run(12);

        // Reset in the middle of a run, then a fresh 1 ms delay.
        pulse_start(32'd3);
        pulses_before = done_edges.size();
        run(5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run(14);
        check_val("no_done_after_reset", longint'(done_edges.size()), longint'(pulses_before));
        pulse_start(32'd1);
        run(6);

        // Level-held start re-triggers every 6 cycles.
        run(3);
        done_edges.delete();
        start_port = 1'b1;
        delay_ms   = 32'd1;
        run(40);
        start_port = 1'b0;
        run(4);
        check_val("held_pulse_count", longint'(done_edges.size() >= 6), 1);
        for (int i = 1; i < done_edges.size(); i++) begin
            check_val("held_spacing", done_edges[i] - done_edges[i-1], 6);
        end

        // Randomized stimulus with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            start_port = ($urandom_range(3, 0) == 0);
            delay_ms   = DW'($urandom_range(5, 0));
            reset      = ($urandom_range(59, 0) == 0);
            tick();
        end
        reset      = 1'b0;
        start_port = 1'b0;
        run(30);

        // All-ones delay on the CLOCK_RATIO=2 instance.
        start2 = 1'b1;
        delay2 = 32'hFFFF_FFFF;
        tick();
        start2 = 1'b0;
        delay2 = '0;
        run(1000);
        check_val("wide_return", longint'(ret2), 1000 / R2);
        check_val("wide_busy", longint'(busy2), 1);
        check_val("wide_done", longint'(done2), 0);
        reset2 = 1'b1;
        tick();
        reset2 = 1'b0;
        check_val("wide_rst_return", longint'(ret2), 0);
        check_val("wide_rst_busy", longint'(busy2), 0);
        check_val("wide_rst_done", longint'(done2), 0);
        // Back in IDLE: a zero delay must complete on the next cycle.
        start2 = 1'b1;
        delay2 = '0;
        tick();
        start2 = 1'b0;
        check_val("wide_idle_done", longint'(done2), 1);
        check_val("wide_idle_busy", longint'(busy2), 0);
        tick();
        check_val("wide_idle_done_end", longint'(done2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
